bcd_display_arbiter: RTL
========================

# bcd_display_arbiter

Shares the board's three-digit decimal seven-segment display among up to four requesters. Each requester presents an 8-bit unsigned value with a req/ack handshake. A round-robin arbiter grants one requester at a time. The granted value is converted to BCD by a sequential shift-add-3 (double-dabble) engine, decoded to active-low segments, and held on HEX2..HEX0 for a programmable dwell period. The block sits between the lab datapaths producing binary results and the physical HEX outputs, replacing per-lab hard-wired decode tables.

## Interface
- `N_REQ`, 4: number of requesters, 1..4.
- `DWELL`, 50_000_000: cycles a granted value is held before re-arbitration; must be ≥1.
- `CLOCK_50` input, 1: sole clock, rising edge.
- `reset` input, 1: synchronous, active-high.
- `req` input, N_REQ: request per channel, level.
- `data` input, 8*N_REQ: channel i value at `data[8*i+7:8*i]`, unsigned.
- `ack` output, N_REQ: one-cycle pulse; `data` for that channel is captured on the edge ending the pulse.
- `busy` output, 1: high in GRANT, CONVERT and SHOW.
- `chan` output, 2: channel whose value is currently displayed.
- `HEX2`, `HEX1`, `HEX0` output, [0:6]: hundreds, tens and ones digits. Bit 0 is segment a and bit 6 is segment g. Active-low.

## Operation
- **States:**
  - IDLE: waits for any `req`.
  - GRANT: one cycle. `ack[g]`=1 and `data` is latched.
  - CONVERT: exactly 8 shift iterations.
  - SHOW: counts DWELL cycles, then returns to IDLE.
- **Arbitration:**
  - Performed only in IDLE.
  - Pointer `last` resets to N_REQ-1, so channel 0 has top priority after reset.
  - Grant goes to the first asserted `req` scanning `last+1`, `last+2`, … modulo N_REQ.
  - On grant, `last` becomes g.
  - Requests are not queued. A `req` deasserted before grant is never served.
  - `req` changes during GRANT, CONVERT or SHOW do not affect the current transaction.
- **Conversion:**
  - 8-bit binary to 12-bit BCD.
  - Before each shift, every BCD nibble ≥5 gets +3.
  - Results are 0..255; the hundreds digit never exceeds 2.
- **Display update:**
  - At the end of CONVERT, HEX2..HEX0 and `chan` update together.
  - They hold until the next conversion completes. With no requests, the display persists indefinitely.
- **Segment codes (a..g):**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- **Reset values:**
  - State IDLE, `ack`=0, `busy`=0, `chan`=0, `last`=N_REQ-1.
  - HEX0 shows 0. HEX2 and HEX1 are set per Configuration.
- **Reset mid-operation:** aborts the transaction. Outputs take their reset values at that edge, and no partial BCD result reaches the display.

## Timing
- Edge E0: IDLE samples `req`, grant is registered, and `ack[g]`/`busy` go high after E0.
- Edge E1: `data[g]` is captured and `ack` returns to 0. Requesters hold `data` stable from `req` assertion through E1.
- Edges E2..E9: the eight shift iterations.
- Edge E10: HEX outputs and `chan` update, and the SHOW counter starts.
- Edge E10+DWELL: return to IDLE, `busy`=0.
- Edge E11+DWELL: earliest next grant.
- Minimum spacing between `ack` pulses is DWELL+11 cycles.
- Concurrent requests are resolved in a single cycle; there are no combinational paths from `req` to `ack`.

## Configuration
- `LEADING_ZERO_BLANK_EN`:
  - **Defined:** HEX2 shows blank when the hundreds digit is 0. HEX1 shows blank when both hundreds and tens are 0. HEX0 always shows a digit. Reset display is blank, blank, 0.
  - **Undefined:** all three digits are always shown. Reset display is 0, 0, 0.

## Test plan
- **Single request.** Reset, DWELL=4. Assert `req[2]` with `data[2]`=137.
  - `ack`=0100 for exactly one cycle after E0.
  - At E10: HEX2=1001111, HEX1=0000110, HEX0=0001111, `chan`=2.
  - `busy` falls at E14.
- **Round robin.** All four `req` held high, DWELL=4.
  - Grant order is 0, 1, 2, 3, 0.
  - `ack` pulses are 15 cycles apart.
- **Extremes.**
  - `data`=255 displays 0010010, 0100100, 0100100.
  - `data`=0 displays blank, blank, 0000001 with `LEADING_ZERO_BLANK_EN`, and 0000001 on all three digits without it.
  - `data`=9 with the macro displays blank, blank, 0000100.
- **Reset mid-CONVERT.** Pulse `reset` at E5.
  - Display stays at the reset pattern.
  - `busy`=0, `ack`=0, `chan`=0.
  - With `req[1]` still high, the next grant goes to channel 1 only if `req[0]`=0.
- **Idle hold and dropped request.**
  - Display 42, then release all `req`: HEX holds 42 for 1000 cycles with `busy`=0.
  - A `req[3]` pulse that falls during SHOW of another channel is never acked.

Source files
------------

// File: rtl/bcd_display_arbiter_if.sv
// Requester bus for bcd_display_arbiter: level req,
// packed 8-bit data per channel, one-cycle ack.
interface bcd_display_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] data;
  logic [N_REQ-1:0]   ack;

  modport master (
    output req,
    output data,
    input  ack
  );

  modport slave (
    input  req,
    input  data,
    output ack
  );
endinterface

// File: rtl/bcd_display_arbiter.sv
// Round-robin share of a 3-digit HEX display with double-dabble BCD.
// `LEADING_ZERO_BLANK_EN blanks leading zero digits on HEX2/HEX1.
module bcd_display_arbiter #(
  parameter int N_REQ = 4,
  parameter int DWELL = 50_000_000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  bcd_display_arbiter_if.slave  bus,
  output logic                  busy,
  output logic [1:0]            chan,
  output logic [0:6]            HEX2,
  output logic [0:6]            HEX1,
  output logic [0:6]            HEX0
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    CONVERT,
    SHOW
  } state_e;

  localparam logic [1:0] LAST_RST = 2'(N_REQ - 1);
  localparam logic [0:6] BLANK    = 7'b1111111;
  localparam logic [0:6] SEG0     = 7'b0000001;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [0:6] HI_RST   = BLANK;
`else
  localparam logic [0:6] HI_RST   = SEG0;
`endif

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       chan_q, chan_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [7:0]       bin_q, bin_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [0:6]       hex2_q, hex2_d;
  logic [0:6]       hex1_q, hex1_d;
  logic [0:6]       hex0_q, hex0_d;

  logic [3:0]  req4;
  logic [31:0] data32;
  logic [3:0]  ack4;
  logic [1:0]  idx;
  logic [1:0]  pick;
  logic        found;
  logic [11:0] adj;
  logic [3:0]  dig_h, dig_t, dig_o;

  function automatic logic [0:6] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = BLANK;
    endcase
  endfunction

  assign req4   = 4'(bus.req);
  assign data32 = 32'(bus.data);
  assign dig_h  = bcd_q[11:8];
  assign dig_t  = bcd_q[7:4];
  assign dig_o  = bcd_q[3:0];

  // Scan last+1, last+2, ... so the previous winner goes last.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = 2'((int'(last_q) + i) % N_REQ);
      if (!found && req4[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 3; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    chan_d  = chan_q;
    ack_d   = '0;
    ack4    = 4'b0001 << pick;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex2_d  = hex2_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          gnt_d   = pick;
          last_d  = pick;
          ack_d   = ack4[N_REQ-1:0];
        end
      end
      GRANT: begin
        bin_d   = data32[{gnt_q, 3'b000} +: 8];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = CONVERT;
      end
      CONVERT: begin
        if (cnt_q == 32'd8) begin
`ifdef LEADING_ZERO_BLANK_EN
          hex2_d = (dig_h == 4'd0) ? BLANK : seg(dig_h);
          hex1_d = (dig_h == 4'd0 && dig_t == 4'd0) ? BLANK : seg(dig_t);
`else
          hex2_d = seg(dig_h);
          hex1_d = seg(dig_t);
`endif
          hex0_d  = seg(dig_o);
          chan_d  = gnt_q;
          cnt_d   = '0;
          state_d = SHOW;
        end else begin
          {bcd_d, bin_d} = {adj, bin_q} << 1;
          cnt_d = cnt_q + 32'd1;
        end
      end
      SHOW: begin
        if (cnt_q == 32'(DWELL - 1))
          state_d = IDLE;
        else
          cnt_d = cnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      gnt_q   <= '0;
      chan_q  <= '0;
      ack_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex2_q  <= HI_RST;
      hex1_q  <= HI_RST;
      hex0_q  <= SEG0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      chan_q  <= chan_d;
      ack_q   <= ack_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
    end
  end

  assign bus.ack = ack_q;
  assign busy    = (state_q != IDLE);
  assign chan    = chan_q;
  assign HEX2    = hex2_q;
  assign HEX1    = hex1_q;
  assign HEX0    = hex0_q;

endmodule
